// File: rtl/mult8_seq_pkg.sv
// Shared types and widths for the sequential 8x8 multiplier built on a 4x4 array core.
package mult8_seq_pkg;

    localparam int OP_W      = 8;
    localparam int HALF_W    = 4;
    localparam int P_W       = 16;
    localparam int NUM_STEPS = 4;
    localparam int STEP_W    = $clog2(NUM_STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/array_mult_structural.sv
// Combinational 4x4 unsigned array multiplier: AND-plane partial products summed by ripple rows.
module array_mult_structural (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] prod
);

    logic [3:0] pp [4];
    logic [4:0] row0;
    logic [4:0] row1;
    logic [4:0] row2;
    logic [4:0] row3;

    // One ripple-carry row of full adders; bit 4 is the row carry-out.
    function automatic logic [4:0] fa_row(input logic [3:0] u, input logic [3:0] v);
        logic [4:0] s;
        logic       c;
        s = '0;
        c = 1'b0;
        for (int j = 0; j < 4; j++) begin
            s[j] = u[j] ^ v[j] ^ c;
            c    = (u[j] & v[j]) | (c & (u[j] ^ v[j]));
        end
        s[4] = c;
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pp[i] = x & {4{y[i]}};
        end
        row0 = {1'b0, pp[0]};
        row1 = fa_row(row0[4:1], pp[1]);
        row2 = fa_row(row1[4:1], pp[2]);
        row3 = fa_row(row2[4:1], pp[3]);
        prod = {row3[4:1], row3[0], row2[0], row1[0], row0[0]};
    end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 multiplier: one shared 4x4 core over four steps, valid/ready on both sides.
// Optional macro MULT8_SEQ_ACC_EN adds acc_en to accumulate products instead of clearing on accept.
module mult8_seq_ctrl
    import mult8_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [P_W-1:0]  p,
`ifdef MULT8_SEQ_ACC_EN
    input  logic            acc_en,
`endif
    output logic            busy
);

    state_t              state;
    state_t              state_nxt;
    logic [STEP_W-1:0]   step;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic [P_W-1:0]      acc;
    logic [HALF_W-1:0]   core_x;
    logic [HALF_W-1:0]   core_y;
    logic [2*HALF_W-1:0] core_prod;
    logic [3:0]          shamt;
    logic [P_W-1:0]      pp_shifted;
    logic                accept;
    logic                keep_acc;

`ifdef MULT8_SEQ_ACC_EN
    assign keep_acc = acc_en;
`else
    assign keep_acc = 1'b0;
`endif

    assign accept = in_valid && in_ready;

    // step[1] picks the a nibble, step[0] the b nibble; shift is 4 per high nibble used.
    assign core_x     = step[1] ? a_q[OP_W-1:HALF_W] : a_q[HALF_W-1:0];
    assign core_y     = step[0] ? b_q[OP_W-1:HALF_W] : b_q[HALF_W-1:0];
    assign shamt      = {step[1] & step[0], step[1] ^ step[0], 2'b00};
    assign pp_shifted = {{(P_W-2*HALF_W){1'b0}}, core_prod} << shamt;

    array_mult_structural u_core (
        .x    (core_x),
        .y    (core_y),
        .prod (core_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = MUL;
            end
            MUL: begin
                if (step == STEP_W'(NUM_STEPS - 1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step <= '0;
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
        end else if (accept) begin
            step <= '0;
            a_q  <= a;
            b_q  <= b;
            acc  <= keep_acc ? acc : '0;
        end else if (state == MUL) begin
            step <= step + 1'b1;
            acc  <= acc + pp_shifted;
        end
    end

    assign p = acc;

endmodule
